// File: rtl/kanagawa_weighted_arbiter_if.sv
// kanagawa_weighted_arbiter_if
// Bundles the producer side (head-of-queue data, empty flags, pop strobes,
// per-port weights) and the consumer side (data, source port, push strobe,
// full flag) of the weighted arbiter.
//   slave  : the arbiter (consumes data_in/empty_in/weights_in/full_in)
//   master : the environment driving producers/consumer
interface kanagawa_weighted_arbiter_if #(
    parameter int unsigned PORTS        = 4,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned WEIGHT_WIDTH = 4
);
    localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PORTS-1:0][WIDTH-1:0]        data_in;
    logic [PORTS-1:0]                   empty_in;
    logic [PORTS-1:0]                   rden_out;
    logic [PORTS-1:0][WEIGHT_WIDTH-1:0] weights_in;
    logic [WIDTH-1:0]                   data_out;
    logic [PW-1:0]                      port_out;
    logic                               wren_out;
    logic                               full_in;

    modport master (
        output data_in, empty_in, weights_in, full_in,
        input  rden_out, data_out, port_out, wren_out
    );

    modport slave (
        input  data_in, empty_in, weights_in, full_in,
        output rden_out, data_out, port_out, wren_out
    );
endinterface

// File: rtl/kanagawa_weighted_arbiter.sv
// kanagawa_weighted_arbiter
// PORTS-input weighted round-robin arbiter with transaction locking. Each
// port owns the output for up to max(weight,1) transactions per turn; a
// transaction in progress is never interleaved with another port's beats.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : kanagawa_weighted_arbiter_if.slave (producers + consumer)
// Optional build macro KANAGAWA_WEIGHTED_ARBITER_OUTPUT_REG_EN inserts a
// one-entry output register (1-cycle latency, full throughput); without it
// the datapath is combinational.
module kanagawa_weighted_arbiter #(
    parameter int unsigned PORTS                  = 4,
    parameter int unsigned WIDTH                  = 8,
    parameter int unsigned WEIGHT_WIDTH           = 4,
    parameter int unsigned IS_TRANSACTIONAL       = 0,
    parameter int unsigned END_TRANSACTION_OFFSET = 0
) (
    input logic                        clk,
    input logic                        rst,
    kanagawa_weighted_arbiter_if.slave bus
);
    localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PW-1:0]           r_ptr_ff;
    logic [WEIGHT_WIDTH-1:0] r_credit_ff;
    logic                    r_locked_ff;

    logic [PW-1:0]           w_sel;
    logic                    w_sel_ok;
    logic                    w_reload;
    logic                    w_accept;
    logic                    w_grant;
    logic                    w_end;
    logic [WIDTH-1:0]        w_beat;
    logic [WEIGHT_WIDTH-1:0] w_weight;
    logic [WEIGHT_WIDTH-1:0] w_credit_eff;

    // Owner selection: locked owner, else owner with credit, else next
    // non-empty port after the owner (owner itself checked last).
    always_comb begin : sel_search
        w_sel    = r_ptr_ff;
        w_sel_ok = 1'b0;
        w_reload = 1'b0;
        if (r_locked_ff) begin
            w_sel_ok = !bus.empty_in[r_ptr_ff];
        end else if (!bus.empty_in[r_ptr_ff] && (r_credit_ff != '0)) begin
            w_sel_ok = 1'b1;
        end else begin
            w_reload = 1'b1;
            // Walk farthest-first so the nearest non-empty port wins.
            for (int k = int'(PORTS); k >= 1; k--) begin
                if (!bus.empty_in[PW'((int'(r_ptr_ff) + k) % int'(PORTS))]) begin
                    w_sel    = PW'((int'(r_ptr_ff) + k) % int'(PORTS));
                    w_sel_ok = 1'b1;
                end
            end
        end
    end

`ifdef KANAGAWA_WEIGHTED_ARBITER_OUTPUT_REG_EN
    logic             r_valid_ff;
    logic [WIDTH-1:0] r_data_ff;
    logic [PW-1:0]    r_port_ff;

    assign w_accept = !r_valid_ff || !bus.full_in;
`else
    assign w_accept = !bus.full_in;
`endif

    // Reset also blocks grants so outputs read zero while rst is held.
    assign w_grant      = w_sel_ok && w_accept && !rst;
    assign w_beat       = bus.data_in[w_sel];
    assign w_weight     = bus.weights_in[w_sel];
    assign w_credit_eff = w_reload ? ((w_weight == '0) ? WEIGHT_WIDTH'(1) : w_weight)
                                   : r_credit_ff;
    assign w_end        = (IS_TRANSACTIONAL != 0) ? w_beat[END_TRANSACTION_OFFSET] : 1'b1;

    // One-hot pop strobe.
    always_comb begin : pop_strobe
        bus.rden_out = '0;
        if (w_grant) begin
            bus.rden_out[w_sel] = 1'b1;
        end
    end

    // Turn state: advances only on a grant.
    always_ff @(posedge clk or posedge rst) begin : turn_state
        if (rst) begin
            r_ptr_ff    <= PW'(PORTS - 1);
            r_credit_ff <= '0;
            r_locked_ff <= 1'b0;
        end else if (w_grant) begin
            r_ptr_ff <= w_sel;
            if (w_end) begin
                r_locked_ff <= 1'b0;
                r_credit_ff <= w_credit_eff - WEIGHT_WIDTH'(1);
            end else begin
                r_locked_ff <= 1'b1;
                r_credit_ff <= w_credit_eff;
            end
        end
    end

`ifdef KANAGAWA_WEIGHTED_ARBITER_OUTPUT_REG_EN
    // One-entry output buffer; refilled in the same cycle it drains.
    always_ff @(posedge clk or posedge rst) begin : out_reg
        if (rst) begin
            r_valid_ff <= 1'b0;
            r_data_ff  <= '0;
            r_port_ff  <= '0;
        end else if (w_grant) begin
            r_valid_ff <= 1'b1;
            r_data_ff  <= w_beat;
            r_port_ff  <= w_sel;
        end else if (r_valid_ff && !bus.full_in) begin
            r_valid_ff <= 1'b0;
        end
    end

    assign bus.wren_out = r_valid_ff && !bus.full_in;
    assign bus.data_out = r_data_ff;
    assign bus.port_out = r_port_ff;
`else
    assign bus.wren_out = w_grant;
    assign bus.data_out = w_grant ? w_beat : '0;
    assign bus.port_out = w_grant ? w_sel : '0;
`endif
endmodule
